// File: rtl/serial_adder_controller.sv
// Bit-serial addition sequencer: drives one shared external full adder LSB first,
// waits SETTLE cycles per bit for it to settle, and chains the carry between bits.
module serial_adder_controller #(
  parameter int WIDTH  = 8,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam int IW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_ZERO = IW'(0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             cy_r;
  logic             carryout_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;
  logic [IW-1:0]    idx_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] acc_next_s;

  assign busy     = busy_r;
  assign done     = done_r;
  assign sum      = sum_r;
  assign carryout = carryout_r;
  assign overflow = overflow_r;
  assign acc_next_s = {fa_sum, acc_r[WIDTH-1:1]};

  // Adder inputs follow the current LSBs of the operand shift registers while waiting.
  always_comb begin
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    if (state_r == S_WAIT) begin
      fa_a   = op_a_r[0];
      fa_b   = op_b_r[0];
      fa_cin = cy_r;
    end else begin
      fa_a   = 1'b0;
      fa_b   = 1'b0;
      fa_cin = 1'b0;
    end
  end

  // Sequencer: accept, per-bit settle/capture, one-cycle done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_IDLE;
      op_a_r     <= {WIDTH{1'b0}};
      op_b_r     <= {WIDTH{1'b0}};
      acc_r      <= {WIDTH{1'b0}};
      sum_r      <= {WIDTH{1'b0}};
      cy_r       <= 1'b0;
      carryout_r <= 1'b0;
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      idx_r      <= IDX_ZERO;
      cnt_r      <= CNT_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            op_a_r  <= a;
            op_b_r  <= b;
            cy_r    <= carryin;
            idx_r   <= IDX_ZERO;
            cnt_r   <= CNT_INIT;
            busy_r  <= 1'b1;
            state_r <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
          end else begin
            acc_r  <= acc_next_s;
            cy_r   <= fa_cout;
            op_a_r <= {1'b0, op_a_r[WIDTH-1:1]};
            op_b_r <= {1'b0, op_b_r[WIDTH-1:1]};
            if (idx_r == IDX_LAST) begin
              // cy_r still holds the carry into the MSB here.
              overflow_r <= cy_r ^ fa_cout;
              carryout_r <= fa_cout;
              sum_r      <= acc_next_s;
              done_r     <= 1'b1;
              state_r    <= S_DONE;
            end else begin
              idx_r <= idx_r + IDX_ONE;
              cnt_r <= CNT_INIT;
            end
          end
        end
        S_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
